// File: rtl/doy_date_converter_if.sv
// rtl/doy_date_converter_if.sv - request/result bundle for the day-of-year date converter
interface doy_date_converter_if;
    logic       start;
    logic [8:0] doy;
    logic       leap;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] month;
    logic [4:0] dom;
    logic [7:0] month_bcd;
    logic [7:0] dom_bcd;

    modport master (
        output start, doy, leap,
        input  busy, done, error, month, dom, month_bcd, dom_bcd
    );

    modport slave (
        input  start, doy, leap,
        output busy, done, error, month, dom, month_bcd, dom_bcd
    );
endinterface

// File: rtl/doy_date_converter.sv
// rtl/doy_date_converter.sv - iterative day-of-year to month/day converter with BCD outputs
module doy_date_converter #(
    parameter int         LEAP_EN     = 1,
    parameter int         ZERO_BLANK  = 1,
    parameter logic [3:0] BLANK_DIGIT = 4'hA
) (
    input  logic                        clk,
    input  logic                        reset,
    doy_date_converter_if.slave         bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WALK,
        S_DONE
    } state_t;

    state_t     state;
    logic [8:0] doy_q;
    logic       leap_q;
    logic [8:0] rem;
    logic [3:0] m;
    logic       busy_q;
    logic       done_q;
    logic       error_q;
    logic [3:0] month_q;
    logic [4:0] dom_q;
    logic [7:0] month_bcd_q;
    logic [7:0] dom_bcd_q;

    logic [8:0] doy_limit;
    logic [8:0] cur_len;

    function automatic logic [4:0] month_len(input logic [3:0] mm, input logic lp);
        case (mm)
            4'd2:                    month_len = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            default:                 month_len = 5'd31;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(v - 5'd30);
        end else if (v >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(v - 5'd20);
        end else if (v >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(v - 5'd10);
        end else begin
            tens = 4'd0;
            ones = v[3:0];
        end
        if (tens == 4'd0 && ZERO_BLANK != 0)
            tens = BLANK_DIGIT;
        to_bcd = {tens, ones};
    endfunction

    assign doy_limit = 9'd365 + {8'd0, leap_q};
    assign cur_len   = {4'd0, month_len(m, leap_q)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            doy_q       <= 9'd0;
            leap_q      <= 1'b0;
            rem         <= 9'd0;
            m           <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            month_q     <= 4'd0;
            dom_q       <= 5'd0;
            month_bcd_q <= {BLANK_DIGIT, BLANK_DIGIT};
            dom_bcd_q   <= {BLANK_DIGIT, BLANK_DIGIT};
        end else begin
            done_q <= 1'b0;
            case (state)
                // DONE accepts a new request exactly like IDLE, giving back-to-back conversions
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        doy_q  <= bus.doy;
                        leap_q <= (LEAP_EN != 0) && bus.leap;
                        busy_q <= 1'b1;
                        state  <= S_CHECK;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (doy_q == 9'd0 || doy_q > doy_limit) begin
                        error_q     <= 1'b1;
                        month_q     <= 4'd0;
                        dom_q       <= 5'd0;
                        month_bcd_q <= {BLANK_DIGIT, BLANK_DIGIT};
                        dom_bcd_q   <= {BLANK_DIGIT, BLANK_DIGIT};
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        rem     <= doy_q;
                        m       <= 4'd1;
                        error_q <= 1'b0;
                        state   <= S_WALK;
                    end
                end
                // rem is strictly larger than cur_len on every subtract, so it never wraps
                S_WALK: begin
                    if (rem <= cur_len) begin
                        month_q     <= m;
                        dom_q       <= rem[4:0];
                        month_bcd_q <= to_bcd({1'b0, m});
                        dom_bcd_q   <= to_bcd(rem[4:0]);
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        rem <= rem - cur_len;
                        m   <= m + 4'd1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.month     = month_q;
    assign bus.dom       = dom_q;
    assign bus.month_bcd = month_bcd_q;
    assign bus.dom_bcd   = dom_bcd_q;
endmodule
